wshb_rr_arbiter: RTL

Round-robin arbiter that shares the single pipelined Wishbone slave port of the SDRAM controller among `NM` masters, such as the VGA frame reader and the pattern (mire) streamer. The grant is registered. A per-grant quota (`MAX_BURST` acknowledged transfers) stops one master from holding the SDRAM indefinitely. When the quota is reached, the arbiter stalls the owner, drains its outstanding requests, and hands the port to the next requester. The arbiter sits between the masters' buses and the SDRAM controller in the `sys_clk` domain.

---
 rtl/wshb_arb_pkg.sv | 26 ++
 rtl/wshb_rr_pick.sv | 25 ++
 rtl/wshb_rr_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/wshb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
// Arbiter states are plain 2-bit constants so older tools can read them as vectors.
package wshb_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE  = 2'd0;
  localparam arb_state_t GRANT = 2'd1;
  localparam arb_state_t DRAIN = 2'd2;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wb_req_t;

  // Counter widths: OUT_W = clog2(MAX_OUT+1), ACK_W = clog2(MAX_BURST+1).
  // The result is clamped to at least 1 so a disabled quota still yields a legal vector.
  function automatic int clog2_min1(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/wshb_rr_pick.sv
// Rotate-priority picker: the first set request at or after last+1, wrapping modulo NM.
module wshb_rr_pick #(
  parameter int NM = 2,
  parameter int IW = 1
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] last,
  output logic [NM-1:0] pick,
  output logic          vld
);

  logic [IW-1:0] idx;

  always_comb begin
    pick = '0;
    idx  = '0;
    for (int i = 1; i <= NM; i++) begin
      idx = IW'((int'(last) + i) % NM);
      if (pick == '0 && req[idx]) pick[idx] = 1'b1;
    end
  end

  assign vld = |req;

endmodule

// File: rtl/wshb_rr_arbiter.sv
// Round-robin arbiter that shares one pipelined Wishbone slave among NM masters.
// The grant is registered, the ack count per grant has a quota, and the outstanding-request count is capped.
module wshb_rr_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int NM        = 2,
  parameter int MAX_BURST = 64,
  parameter int MAX_OUT   = 15
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [NM-1:0]        m_cyc,
  input  logic [NM-1:0]        m_stb,
  input  logic [NM-1:0]        m_we,
  input  logic [NM-1:0][31:0]  m_adr,
  input  logic [NM-1:0][3:0]   m_sel,
  input  logic [NM-1:0][31:0]  m_dat_w,
  output logic [NM-1:0]        m_ack,
  output logic [NM-1:0]        m_stall,
  output logic [31:0]          m_dat_r,
  output logic                 s_cyc,
  output logic                 s_stb,
  output logic                 s_we,
  output logic [31:0]          s_adr,
  output logic [3:0]           s_sel,
  output logic [31:0]          s_dat_w,
  input  logic                 s_ack,
  input  logic                 s_stall,
  input  logic [31:0]          s_dat_r,
  output logic [NM-1:0]        grant
);

  localparam int IW    = clog2_min1(NM);
  localparam int OUT_W = clog2_min1(MAX_OUT + 1);
  localparam int ACK_W = clog2_min1(MAX_BURST + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);
  localparam logic [ACK_W-1:0] ACK_MAX = ACK_W'(MAX_BURST);

  arb_state_t       state;
  logic [IW-1:0]    owner, last, pick_idx;
  logic [NM-1:0]    owner_oh, pick_oh;
  logic             pick_vld;
  logic [OUT_W-1:0] out_cnt, out_nxt;
  logic [ACK_W-1:0] ack_cnt;
  wb_req_t          own;
  logic             busy, at_limit, issue, ack_dec, rivals, quota_hit;

  wshb_rr_pick #(.NM(NM), .IW(IW)) u_pick (
    .req  (m_cyc),
    .last (last),
    .pick (pick_oh),
    .vld  (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NM; i++)
      if (pick_oh[i]) pick_idx = IW'(i);
  end

  assign owner_oh = NM'(1) << owner;

  always_comb
    own = '{cyc: m_cyc[owner], stb: m_stb[owner], we: m_we[owner],
            adr: m_adr[owner], sel: m_sel[owner], dat: m_dat_w[owner]};

  assign busy      = (state != IDLE);
  assign at_limit  = (out_cnt == OUT_MAX);
  assign rivals    = |(m_cyc & ~owner_oh);
  assign quota_hit = (MAX_BURST != 0) && (ack_cnt >= ACK_MAX) && rivals;

  // Slave-side and master-side muxing; IDLE keeps every slave output at zero.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_sel   = '0;
    s_dat_w = '0;
    m_stall = '1;
    m_ack   = '0;
    grant   = '0;
    if (state == GRANT) begin
      s_cyc          = own.cyc;
      s_stb          = own.stb & ~at_limit;
      m_stall[owner] = s_stall | at_limit;
    end else if (state == DRAIN) begin
      s_cyc = 1'b1;
    end
    if (busy) begin
      s_we         = own.we;
      s_adr        = own.adr;
      s_sel        = own.sel;
      s_dat_w      = own.dat;
      m_ack[owner] = s_ack;
      grant        = owner_oh;
    end
  end

  assign m_dat_r = s_dat_r;

  // A simultaneous issue and ack cancel out; an ack with nothing in flight is ignored.
  assign issue   = s_stb & ~s_stall;
  assign ack_dec = busy & s_ack & (issue | (out_cnt != '0));

  always_comb begin
    out_nxt = out_cnt;
    case ({issue, ack_dec})
      2'b10:   out_nxt = out_cnt + 1'b1;
      2'b01:   out_nxt = out_cnt - 1'b1;
      default: out_nxt = out_cnt;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      owner   <= '0;
      last    <= IW'(NM - 1);
      out_cnt <= '0;
      ack_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_cnt <= '0;
          ack_cnt <= '0;
          if (pick_vld) begin
            owner <= pick_idx;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!own.cyc) begin
            // Whatever is still in flight belongs to an abandoned cycle.
            last    <= owner;
            out_cnt <= '0;
            state   <= IDLE;
          end else begin
            out_cnt <= out_nxt;
            if (busy && s_ack && ack_cnt < ACK_MAX) ack_cnt <= ack_cnt + 1'b1;
            if (quota_hit) state <= DRAIN;
          end
        end
        DRAIN: begin
          out_cnt <= out_nxt;
          if (out_nxt == '0) begin
            last  <= owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
